led_status_ctrl: RTL and testbench

Board LED status controller that arbitrates four LEDs among a heartbeat, UART/FIFO/DDR activity indicators, a power-up lamp test and an error alarm. Each LED is owned by one source in normal operation. A single priority state machine overrides all four LEDs during lamp test and error. It sits at the top level beside the UART→FIFO→DDR datapath and consumes single-cycle event pulses from it.

---
 rtl/led_status_ctrl.sv | 148 ++++++++++++++
 tb/tb_led_status_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_ctrl.sv
// Board LED status controller: lamp test, heartbeat, activity stretchers and error blink.
// Define LED_ERR_LATCH_EN to make the error state sticky until reset.
module led_status_ctrl #(
  parameter int HB_DIV  = 10000000,
  parameter int STRETCH = 1000000,
  parameter int ERR_DIV = 2500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hb_en,
  input  logic i_uart_rx_evt,
  input  logic i_uart_tx_evt,
  input  logic i_fifo_evt,
  input  logic i_ddr_evt,
  input  logic i_err,
  output logic led_1,
  output logic led_2,
  output logic led_3,
  output logic led_4,
  output logic o_err_active
);

  localparam int HBW = $clog2(HB_DIV + 1);
  localparam int SW  = $clog2(STRETCH + 1);
  localparam int EW  = $clog2(ERR_DIV + 1);

  localparam logic [HBW-1:0] HB_LAST      = HBW'(HB_DIV - 1);
  localparam logic [SW-1:0]  STRETCH_LOAD = SW'(STRETCH);
  localparam logic [EW-1:0]  ERR_LAST     = EW'(ERR_DIV - 1);

  typedef enum logic [1:0] {
    ST_LAMP   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [HBW-1:0] hb_cnt;
  logic [HBW-1:0] lamp_cnt;
  logic           hb;
  logic [SW-1:0]  rx_cnt, tx_cnt, act_cnt;
  logic [EW-1:0]  blink_cnt;
  logic           blink;
  logic [3:0]     led_nxt;

  // Heartbeat runs in every state so its phase survives lamp test and error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HBW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lamp_cnt <= '0;
    end else if (state == ST_LAMP && lamp_cnt != HB_LAST) begin
      lamp_cnt <= lamp_cnt + HBW'(1);
    end
  end

  // Retrigger reloads rather than accumulates; FIFO and DDR share one stretcher.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      act_cnt <= '0;
    end else begin
      rx_cnt  <= i_uart_rx_evt ? STRETCH_LOAD :
                 (rx_cnt != '0) ? rx_cnt - SW'(1) : rx_cnt;
      tx_cnt  <= i_uart_tx_evt ? STRETCH_LOAD :
                 (tx_cnt != '0) ? tx_cnt - SW'(1) : tx_cnt;
      act_cnt <= (i_fifo_evt | i_ddr_evt) ? STRETCH_LOAD :
                 (act_cnt != '0) ? act_cnt - SW'(1) : act_cnt;
    end
  end

  // Blink phase is held at 1 outside ERROR so every entry starts lit.
  always_ff @(posedge i_clk) begin
    if (i_rst || state != ST_ERROR) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (blink_cnt == ERR_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + EW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_LAMP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = 4'b0000;
    case (state)
      ST_LAMP: begin
        led_nxt = 4'b1111;
        if (i_err) begin
          state_nxt = ST_ERROR;
        end else if (lamp_cnt == HB_LAST) begin
          state_nxt = ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        led_nxt = {act_cnt != '0, tx_cnt != '0, rx_cnt != '0, hb & i_hb_en};
        if (i_err) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: begin
        led_nxt = {4{blink}};
`ifdef LED_ERR_LATCH_EN
        state_nxt = ST_ERROR;
`else
        if (!i_err) begin
          state_nxt = ST_NORMAL;
        end
`endif
      end
      default: begin
        state_nxt = ST_LAMP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {led_4, led_3, led_2, led_1} <= 4'b0000;
      o_err_active                 <= 1'b0;
    end else begin
      {led_4, led_3, led_2, led_1} <= led_nxt;
      o_err_active                 <= (state == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl: directed scenarios plus random traffic
// compared against an edge-time reference model.
module tb_led_status_ctrl;

  localparam int HB_DIV  = 8;
  localparam int STRETCH = 4;
  localparam int ERR_DIV = 3;
  localparam int M_LAMP   = 0;
  localparam int M_NORMAL = 1;
  localparam int M_ERROR  = 2;
`ifdef LED_ERR_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hb_en = 1'b1;
  logic rx = 1'b0, tx = 1'b0, fifo = 1'b0, ddr = 1'b0, err = 1'b0;
  logic led_1, led_2, led_3, led_4, o_err_active;
  logic [3:0] leds;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: edge index since the last reset edge, mode, last event edges.
  int edge_k = 0;
  int mode = M_LAMP;
  int err_entry = 0;
  int last_evt[3] = '{-100000, -100000, -100000};
  logic [3:0] exp_led = 4'b0000;
  logic exp_err = 1'b0;

  assign leds = {led_4, led_3, led_2, led_1};

  led_status_ctrl #(
    .HB_DIV (HB_DIV),
    .STRETCH(STRETCH),
    .ERR_DIV(ERR_DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hb_en      (hb_en),
    .i_uart_rx_evt(rx),
    .i_uart_tx_evt(tx),
    .i_fifo_evt   (fifo),
    .i_ddr_evt    (ddr),
    .i_err        (err),
    .led_1        (led_1),
    .led_2        (led_2),
    .led_3        (led_3),
    .led_4        (led_4),
    .o_err_active (o_err_active)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [3:0] l;
    logic e;
    logic b;
    l = 4'b0000;
    e = 1'b0;
    if (rst) begin
      exp_led = 4'b0000;
      exp_err = 1'b0;
      edge_k = 0;
      mode = M_LAMP;
      for (int j = 0; j < 3; j++) last_evt[j] = -100000;
      return;
    end
    edge_k++;
    case (mode)
      M_LAMP: l = 4'b1111;
      M_NORMAL: begin
        l[0] = hb_en & ((((edge_k - 1) / HB_DIV) % 2) == 1);
        l[1] = (last_evt[0] >= edge_k - STRETCH);
        l[2] = (last_evt[1] >= edge_k - STRETCH);
        l[3] = (last_evt[2] >= edge_k - STRETCH);
      end
      default: begin
        b = ((((edge_k - 1 - err_entry) / ERR_DIV) % 2) == 0);
        l = {4{b}};
        e = 1'b1;
      end
    endcase
    exp_led = l;
    exp_err = e;
    if (rx) last_evt[0] = edge_k;
    if (tx) last_evt[1] = edge_k;
    if (fifo || ddr) last_evt[2] = edge_k;
    case (mode)
      M_LAMP: begin
        if (err) begin
          mode = M_ERROR;
          err_entry = edge_k;
        end else if (edge_k == HB_DIV) begin
          mode = M_NORMAL;
        end
      end
      M_NORMAL: begin
        if (err) begin
          mode = M_ERROR;
          err_entry = edge_k;
        end
      end
      default: begin
        if (!LATCH && !err) mode = M_NORMAL;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    rx = 1'b0; tx = 1'b0; fifo = 1'b0; ddr = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hb_en = 1'b1;
    clear_inputs();
    tick();
    tick();
    n_checks++;
    if (leds !== exp_led || o_err_active !== exp_err) begin
      n_fail++;
      $display("[TB] FAIL reset_model: leds=%b err=%b, expected leds=%b err=%b",
               leds, o_err_active, exp_led, exp_err);
    end
    n_checks++;
    if (leds !== 4'b0000 || o_err_active !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_zero: leds=%b err=%b, expected leds=0000 err=0",
               leds, o_err_active);
    end
  endtask

  task automatic test_lamp_heartbeat();
    logic hb_ref;
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL lamp_hb_model cycle %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
      hb_ref = ((((i - 1) / HB_DIV) % 2) == 1);
      n_checks++;
      if (i <= HB_DIV) begin
        if (leds !== 4'b1111) begin
          n_fail++;
          $display("[TB] FAIL lamp_on cycle %0d: leds=%b, expected 1111", i, leds);
        end
      end else if (leds !== {3'b000, hb_ref}) begin
        n_fail++;
        $display("[TB] FAIL heartbeat cycle %0d: leds=%b, expected %b",
                 i, leds, {3'b000, hb_ref});
      end
    end
  endtask

  task automatic test_single_stretch();
    for (int i = 0; i <= 6; i++) begin
      rx = (i == 0);
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL stretch_model step %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
      if (i >= 1) begin
        n_checks++;
        if (led_2 !== (i <= STRETCH) || led_3 !== 1'b0 || led_4 !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stretch_single step %0d: led2..4=%b%b%b, expected %b00",
                   i, led_2, led_3, led_4, (i <= STRETCH));
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_retrigger_merge();
    for (int i = 0; i <= 8; i++) begin
      rx = (i == 0 || i == 2);
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL retrigger_model step %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
      if (i >= 1) begin
        n_checks++;
        if (led_2 !== (i <= 6)) begin
          n_fail++;
          $display("[TB] FAIL retrigger step %0d: led_2=%b, expected %b", i, led_2, (i <= 6));
        end
      end
    end
    rx = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      fifo = (i == 0);
      ddr  = (i == 0);
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL merge_model step %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
      if (i >= 1) begin
        n_checks++;
        if (led_4 !== (i <= STRETCH)) begin
          n_fail++;
          $display("[TB] FAIL merge step %0d: led_4=%b, expected %b", i, led_4, (i <= STRETCH));
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_hb_gating();
    logic hb_ref;
    hb_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (leds !== exp_led || led_1 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hb_gated step %0d: leds=%b, expected leds=%b led_1=0",
                 i, leds, exp_led);
      end
    end
    hb_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      hb_ref = ((((edge_k - 1) / HB_DIV) % 2) == 1);
      n_checks++;
      if (leds !== exp_led || led_1 !== hb_ref) begin
        n_fail++;
        $display("[TB] FAIL hb_reenable step %0d: leds=%b, expected leds=%b led_1=%b",
                 i, leds, exp_led, hb_ref);
      end
    end
  endtask

  task automatic test_error_blink();
    bit pat[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    for (int i = 0; i <= 13; i++) begin
      err = (i < 10);
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL err_model step %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
      if (i >= 1 && i <= 10) begin
        n_checks++;
        if (leds !== {4{pat[i-1]}} || o_err_active !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL err_blink step %0d: leds=%b err=%b, expected leds=%b err=1",
                   i, leds, o_err_active, {4{pat[i-1]}});
        end
      end else if (i >= 11) begin
        n_checks++;
        if (o_err_active !== LATCH) begin
          n_fail++;
          $display("[TB] FAIL err_exit step %0d: err_active=%b, expected %b",
                   i, o_err_active, LATCH);
        end
      end
    end
    if (LATCH) begin
      for (int i = 0; i < 50; i++) begin
        tick();
        n_checks++;
        if (leds !== exp_led || o_err_active !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL err_latched step %0d: leds=%b err=%b, expected leds=%b err=1",
                   i, leds, o_err_active, exp_led);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_error();
    err = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (o_err_active !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_err_pre: err_active=%b, expected 1", o_err_active);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (leds !== 4'b0000 || o_err_active !== 1'b0 || exp_led !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL rst_err_zero: leds=%b err=%b, expected leds=0000 err=0",
               leds, o_err_active);
    end
    rst = 1'b0;
    err = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== 1'b0 ||
          (i <= HB_DIV && leds !== 4'b1111)) begin
        n_fail++;
        $display("[TB] FAIL rst_err_lamp cycle %0d: leds=%b err=%b, expected leds=%b err=0",
                 i, leds, o_err_active, exp_led);
      end
    end
  endtask

  task automatic test_err_during_lamp();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      err = (i == 3);
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL lamp_err_model cycle %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
      if (i == 4) begin
        n_checks++;
        if (o_err_active !== 1'b1 || leds !== 4'b1111) begin
          n_fail++;
          $display("[TB] FAIL lamp_err_entry: leds=%b err=%b, expected leds=1111 err=1",
                   leds, o_err_active);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int err_len;
    err_len = 0;
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) hb_en = ~hb_en;
      rx   = ($urandom_range(0, 5) == 0);
      tx   = ($urandom_range(0, 6) == 0);
      fifo = ($urandom_range(0, 7) == 0);
      ddr  = ($urandom_range(0, 7) == 0);
      if (err_len > 0) begin
        err_len--;
      end else if ($urandom_range(0, 59) == 0) begin
        err_len = $urandom_range(1, 12);
      end
      err = (err_len > 0);
      tick();
      n_checks++;
      if (leds !== exp_led || o_err_active !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: leds=%b err=%b, expected leds=%b err=%b",
                 i, leds, o_err_active, exp_led, exp_err);
      end
    end
    clear_inputs();
    rst = 1'b0;
    hb_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lamp_heartbeat();
    test_single_stretch();
    test_retrigger_merge();
    test_hb_gating();
    test_error_blink();
    test_reset_in_error();
    test_err_during_lamp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
